// File: rtl/led_mode_selector.sv
// Push-button front end for the LED mode drivers. It synchronises and debounces key_n.
// A short press advances the mode index; a long press toggles the global LED enable.
module led_mode_selector #(
  parameter int NUM_MODES      = 4,
  parameter int DEBOUNCE_CYC   = 12,
  parameter int LONG_PRESS_CYC = 600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_n,
  output logic [2:0] mode_out,
  output logic [7:0] led_select,
  output logic       led_enable,
  output logic       mode_change
);

  localparam int DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int HW = (LONG_PRESS_CYC > 1) ? $clog2(LONG_PRESS_CYC) : 1;
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYC - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYC - 1);
  localparam logic [2:0]    MODE_LAST = 3'(NUM_MODES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESSED   = 2'd1,
    LONG_HELD = 2'd2
  } state_t;

  // Handshake-free block: key_n is a level input, and every output is a registered level or pulse.
  logic          s1, s2;
  logic          key_db;
  logic [DW-1:0] deb_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1      <= 1'b1;
      s2      <= 1'b1;
      key_db  <= 1'b1;
      deb_cnt <= '0;
    end else begin
      s1 <= key_n;
      s2 <= s1;
      if (s2 != key_db) begin
        if (deb_cnt == DEB_LAST) begin
          key_db  <= s2;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  state_t        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [2:0]    mode_d;
  logic          en_d;
  logic          change_d;
  logic [7:0]    sel_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      mode_out    <= 3'd0;
      led_enable  <= 1'b1;
      led_select  <= 8'h01;
      mode_change <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      mode_out    <= mode_d;
      led_enable  <= en_d;
      led_select  <= sel_d;
      mode_change <= change_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    mode_d   = mode_out;
    en_d     = led_enable;
    change_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!key_db) begin
          state_d = PRESSED;
          hold_d  = '0;
        end
      end
      PRESSED: begin
        // Release is tested first so a release on the threshold cycle still counts as short.
        if (key_db) begin
          mode_d   = (mode_out == MODE_LAST) ? 3'd0 : mode_out + 3'd1;
          change_d = 1'b1;
          state_d  = IDLE;
        end else if (hold_q == HOLD_LAST) begin
          en_d    = ~led_enable;
          state_d = LONG_HELD;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      LONG_HELD: begin
        if (key_db) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    sel_d = en_d ? (8'b1 << mode_d) : 8'h00;
  end

endmodule

// File: doc/led_mode_selector.md
Name: led_mode_selector

Overview:
Front-end control block for the LED mode drivers. It takes the raw push-button, synchronises and debounces it, and classifies each press as short or long. A short press advances the active LED mode; a long press toggles the global LED enable. It drives the led_select / mode inputs consumed by the LED_modeN drivers and runs on the same slow (~600 Hz) LED clock.

Parameters:
NUM_MODES, 4, number of LED modes; legal range 2..8; mode wraps NUM_MODES-1 -> 0
DEBOUNCE_CYC, 12, clk cycles the synchronised key must hold a new level before it is accepted (~20 ms at 600 Hz)
LONG_PRESS_CYC, 600, clk cycles of debounced press that make it a long press (~1 s at 600 Hz)

Ports:
clk  input  1  LED system clock
rst_n  input  1  asynchronous, active-low reset
key_n  input  1  raw push-button, active-low, asynchronous to clk
mode_out  output  3  current mode index, 0..NUM_MODES-1
led_select  output  8  one-hot of mode_out when enabled, else 8'h00
led_enable  output  1  global LED enable
mode_change  output  1  one-cycle pulse in the cycle mode_out takes a new value

Behaviour:
- Reset is asynchronous, active-low; clock is clk. All state is flops in a clk/negedge rst_n process.
- Reset values: mode_out=0, led_select=8'h01, led_enable=1, mode_change=0, FSM=IDLE, both sync flops=1, key_db=1, all counters=0.
- Synchroniser: 2 flops on key_n; s2 is the synchronised level.
- Debouncer:
  - key_db is the accepted level (1 = released).
  - If s2 != key_db, deb_cnt increments.
  - If deb_cnt == DEBOUNCE_CYC-1 and s2 still != key_db, key_db <= s2 and deb_cnt <= 0.
  - If s2 == key_db, deb_cnt <= 0. Any glitch shorter than DEBOUNCE_CYC cycles is fully discarded.
  - Counter width is $clog2(DEBOUNCE_CYC).
- Press FSM (hold_cnt width $clog2(LONG_PRESS_CYC)):
  - IDLE: key_db falls 1->0 -> PRESSED, hold_cnt <= 0.
  - PRESSED, key_db == 1 (released) before the long-press threshold -> short press. mode_out <= (mode_out == NUM_MODES-1) ? 0 : mode_out+1; mode_change <= 1 for one cycle; -> IDLE.
  - PRESSED, still pressed and hold_cnt == LONG_PRESS_CYC-1 -> led_enable <= ~led_enable; -> LONG_HELD. No mode change.
  - PRESSED otherwise: hold_cnt increments.
  - LONG_HELD: stays until key_db == 1, then -> IDLE. No action on release, no repeat toggling.
- led_select is registered and updates on the same edge as mode_out / led_enable: led_enable ? (8'b1 << mode_out) : 8'h00.
- mode_change is high for exactly one cycle per short press and is never asserted on a long press.
- Latency: from key_n settling to key_db changing = 2 (sync) + DEBOUNCE_CYC cycles. On a short release, mode_out, led_select and mode_change all update on the edge after key_db rises.
- Reset mid-operation: outputs return to reset values immediately; any in-progress press is discarded.
- If key_n is held low through reset release, it is treated as a new press after the debounce interval.
- Simultaneous events: the release check has priority over the long-press threshold in the same cycle, so the press counts as short.
- Mode 0 is always reachable; a NUM_MODES outside 2..8 is a configuration error, with no runtime checking.

Test Plan:
(Sim parameters: NUM_MODES=4, DEBOUNCE_CYC=4, LONG_PRESS_CYC=16.)
- Reset, key released -> mode_out=0, led_select=8'h01, led_enable=1, mode_change=0.
- key_n low for 3 cycles then high -> key_db never falls; all outputs unchanged; mode_change never pulses.
- key_n low for 10 cycles then high -> after release debounce, mode_out=1, led_select=8'h02, mode_change high for exactly 1 cycle.
- Four short presses of 10 cycles each -> mode_out sequence 1,2,3,0; led_select sequence 02,04,08,01; four single-cycle pulses.
- key_n low for 30 cycles -> led_enable=0 and led_select=8'h00 at 2+4+16 cycles after press; mode_out unchanged; no pulse on release. A second long press -> led_enable=1, led_select restored to the one-hot of the current mode.
- Assert rst_n low while FSM is in PRESSED (hold_cnt=8) -> outputs return to reset values asynchronously. Release reset with key still low -> a press is recognised after debounce and, on release, gives mode_out=1.
